// File: rtl/div_seq_responder.sv
// Multicycle signed restoring divider (MIPS DIV semantics): quotient to lo, remainder to hi.
// Retires one quotient bit per cycle behind a start/done handshake and flags divide-by-zero.
module div_seq_responder #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_DONE, S_ZERO} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q, r_sign_r;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_div_is_zero;
    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic             w_last;

    assign w_div_is_zero = (divisor == '0);
    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
    assign w_a_abs  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_b_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_rem_sh = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_last   = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = w_div_is_zero ? S_ZERO : S_RUN;
            S_RUN:  if (w_last) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            S_ZERO: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start && !w_div_is_zero) begin
                    r_q      <= w_a_abs;
                    r_dvs    <= w_b_abs;
                    r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_sign_r <= dividend[WIDTH-1];
                    r_rem    <= '0;
                    r_count  <= '0;
                end
                S_RUN: begin
                    r_rem   <= w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
                    r_q     <= {r_q[WIDTH-2:0], w_ge};
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_lo <= r_sign_q ? (~r_q + 1'b1) : r_q;
                    r_hi <= r_sign_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode the state register only, so nothing combinational reaches them from inputs.
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE) || (r_state == S_ZERO);
    assign div_zero = (r_state == S_ZERO);
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule
